dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder for the pipelined CPU's MEM stage: the slave end of the MemRead/MemWrite
//  interface. Models a word-addressed RAM with a fixed, parameterised access latency.
//  Raises a stall towards the pipeline while an access is in flight, returns read data with a
//  done pulse, and flags misaligned or out-of-range requests.
// PARAMETERS
//  DEPTH    128  number of 32-bit words; legal word index 0..DEPTH-1
//  LATENCY  2    wait cycles between request acceptance and completion; legal range 0..15
// PORTS
//  clk_i        in   1   clock; all state updates on rising edge
//  rst_i        in   1   synchronous reset, active-low
//  mem_read_i   in   1   read request from MEM stage (level, held while stalled)
//  mem_write_i  in   1   write request from MEM stage (level, held while stalled)
//  addr_i       in   32  byte address; must be word-aligned
//  wdata_i      in   32  write data
//  rdata_o      out  32  registered read data; holds last completed read
//  done_o       out  1   one-cycle pulse: access completed this cycle
//  err_o        out  1   one-cycle pulse: request rejected (misaligned or out of range)
//  stall_o      out  1   combinational; high = pipeline must hold IF/ID/EX/MEM registers
// BEHAVIOUR
//  Reset (rst_i==0 at edge): state=IDLE, wait counter=0, rdata_o=0, done_o=0, err_o=0.
//  stall_o is forced to 0 while rst_i==0. RAM contents are not cleared.
//  req = mem_read_i | mem_write_i.
//  bad = addr_i[1:0]!=0 | addr_i[31:2]>=DEPTH.
//  Op select: write has priority when both requests are high. The write is performed; no read
//  data is returned; err_o is not raised.
//  FSM states: IDLE, WAIT, RESP.
//  IDLE:
//   - no req: stay in IDLE; stall_o=0.
//   - req & bad: no RAM access; err_o=1 next cycle; stay in IDLE; stall_o=0.
//   - req & !bad: latch op, word index and wdata; stall_o=1 this cycle.
//     LATENCY>0: go to WAIT with counter=LATENCY-1.
//     LATENCY==0: go directly to RESP.
//  WAIT:
//   - stall_o=1; request inputs are ignored.
//   - counter!=0: decrement and stay in WAIT.
//   - counter==0: perform the latched access (write RAM, or load rdata_o from RAM); go to RESP.
//  RESP:
//   - done_o=1 and stall_o=0, so the pipeline advances at the end of this cycle.
//   - The still-visible old request is ignored; go to IDLE. A new request is sampled in IDLE
//     on the following cycle.
//  Timing: request accepted in cycle T. stall_o is high for cycles T..T+LATENCY
//  (LATENCY+1 cycles). done_o and the new rdata_o are visible in cycle T+LATENCY+1.
//  A write leaves rdata_o unchanged.
//  A write and a read to the same word in consecutive requests: the read returns the new data.
//  Reset in WAIT or RESP: return to IDLE; the pending write is dropped (RAM not written);
//  no done_o is issued.
//  Counter is 4 bits.
//  Input changes during WAIT do not alter the latched op, address or data.
// TESTING
//  1. LATENCY=2: write 0xDEADBEEF @0x10, then read @0x10 -> each access stalls 3 cycles;
//     done_o at T+3; rdata_o=0xDEADBEEF.
//  2. LATENCY=0: read @0x0 after a write of 0x12345678 -> stall_o high only in cycle T;
//     done_o at T+1 with the correct data.
//  3. Read @0x6 (misaligned) and @0x200 with DEPTH=128 -> err_o pulses once; stall_o stays 0;
//     rdata_o unchanged.
//  4. Reset asserted mid-WAIT of a write 0xA5A5A5A5 @0x8 -> IDLE; done_o=0; later read @0x8
//     returns the prior contents.
//  5. mem_read_i & mem_write_i both high, wdata 0x55 @0x4 -> write performed; rdata_o unchanged;
//     a read @0x4 returns 0x55.
//  6. Back-to-back reads @0x0, @0x4 held by pipeline -> two separate 3-cycle stalls with one
//     idle cycle between; correct data on each done_o.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: word-addressed RAM with a fixed access latency,
// a combinational stall towards the pipeline and registered read data with a done pulse.
`timescale 1ns/1ps

module dmem_responder #(
    parameter int DEPTH   = 128,
    parameter int LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        done_o,
    output logic        err_o,
    output logic        stall_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               op_write_q;
    logic [IDX_W-1:0]   idx_q;
    logic [31:0]        wdata_q;
    logic               err_d;
    logic               latch_en;
    logic               access_en;

    logic [31:0]        mem [DEPTH];

    logic               req;
    logic               bad;
    logic [29:0]        word_addr;
    logic               acc_write;
    logic [IDX_W-1:0]   acc_idx;
    logic [31:0]        acc_wdata;

    assign req       = mem_read_i | mem_write_i;
    assign word_addr = addr_i[31:2];
    assign bad       = (addr_i[1:0] != 2'b00) || (word_addr >= 30'(DEPTH));

    // With zero latency the access happens on the accepting edge, so it must use the live inputs.
    assign acc_write = (state_q == S_IDLE) ? mem_write_i       : op_write_q;
    assign acc_idx   = (state_q == S_IDLE) ? addr_i[IDX_W+1:2] : idx_q;
    assign acc_wdata = (state_q == S_IDLE) ? wdata_i           : wdata_q;

    assign done_o = (state_q == S_RESP);

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        latch_en  = 1'b0;
        access_en = 1'b0;
        stall_o   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req && bad) begin
                    err_d = 1'b1;
                end else if (req) begin
                    latch_en = 1'b1;
                    stall_o  = 1'b1;
                    if (LATENCY == 0) begin
                        access_en = 1'b1;
                        state_d   = S_RESP;
                    end else begin
                        cnt_d   = 4'(LATENCY - 1);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                stall_o = 1'b1;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    access_en = 1'b1;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (!rst_i) begin
            stall_o = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_o <= 32'd0;
            err_o   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_o   <= err_d;
            if (access_en && !acc_write) begin
                rdata_o <= mem[acc_idx];
            end
        end
    end

    // Request latches carry no reset: they are only consumed after being loaded on acceptance.
    always_ff @(posedge clk_i) begin
        if (latch_en) begin
            op_write_q <= mem_write_i;
            idx_q      <= addr_i[IDX_W+1:2];
            wdata_q    <= wdata_i;
        end
    end

    // NOTE: RAM contents are never reset; reset only gates off a pending write.
    always_ff @(posedge clk_i) begin
        if (rst_i && access_en && acc_write) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance and a LATENCY=0 instance,
// each driven with hand-computed request/response expectations.
`timescale 1ns/1ps

module tb_dmem_responder;

    logic        clk;
    logic [1:0]  rst;
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic [1:0]  done;
    logic [1:0]  err;
    logic [1:0]  stall;

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(128), .LATENCY(2)) dut_l2 (
        .clk_i      (clk),
        .rst_i      (rst[0]),
        .mem_read_i (rd[0]),
        .mem_write_i(wr[0]),
        .addr_i     (addr[0]),
        .wdata_i    (wdata[0]),
        .rdata_o    (rdata[0]),
        .done_o     (done[0]),
        .err_o      (err[0]),
        .stall_o    (stall[0])
    );

    dmem_responder #(.DEPTH(128), .LATENCY(0)) dut_l0 (
        .clk_i      (clk),
        .rst_i      (rst[1]),
        .mem_read_i (rd[1]),
        .mem_write_i(wr[1]),
        .addr_i     (addr[1]),
        .wdata_i    (wdata[1]),
        .rdata_o    (rdata[1]),
        .done_o     (done[1]),
        .err_o      (err[1]),
        .stall_o    (stall[1])
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic idle(input int s);
        @(negedge clk);
        rd[s] = 1'b0;
        wr[s] = 1'b0;
        #1;
    endtask

    // One valid access held until done; checks stall length, single done pulse and rdata.
    task automatic access(input int s, input bit w, input bit r, input logic [31:0] a,
                          input logic [31:0] d, input bit scramble,
                          input logic [31:0] exp_rd, input int lat);
        int stalls = 0;
        bit seen   = 1'b0;
        @(negedge clk);
        wr[s] = w; rd[s] = r; addr[s] = a; wdata[s] = d;
        #1;
        check($sformatf("u%0d_stall_T@%0h", s, a), 32'(stall[s]), 32'd1);
        check($sformatf("u%0d_done_T@%0h", s, a), 32'(done[s]), 32'd0);
        for (int k = 0; k < 40; k++) begin
            if (done[s]) begin
                seen = 1'b1;
                break;
            end
            if (stall[s]) stalls++;
            @(negedge clk);
            if (scramble) begin
                addr[s]  = a ^ 32'h4;
                wdata[s] = ~d;
            end
            #1;
        end
        check($sformatf("u%0d_done_seen@%0h", s, a), 32'(seen), 32'd1);
        check($sformatf("u%0d_stall_cycles@%0h", s, a), 32'(stalls), 32'(lat + 1));
        check($sformatf("u%0d_stall_resp@%0h", s, a), 32'(stall[s]), 32'd0);
        check($sformatf("u%0d_rdata@%0h", s, a), rdata[s], exp_rd);
    endtask

    // Rejected read: no stall, single err pulse next cycle, rdata untouched.
    task automatic bad_read(input logic [31:0] a, input logic [31:0] exp_rd);
        @(negedge clk);
        rd[0] = 1'b1; wr[0] = 1'b0; addr[0] = a;
        #1;
        check($sformatf("bad_stall@%0h", a), 32'(stall[0]), 32'd0);
        check($sformatf("bad_err_early@%0h", a), 32'(err[0]), 32'd0);
        idle(0);
        check($sformatf("bad_err@%0h", a), 32'(err[0]), 32'd1);
        check($sformatf("bad_rdata@%0h", a), rdata[0], exp_rd);
        idle(0);
        check($sformatf("bad_err_once@%0h", a), 32'(err[0]), 32'd0);
        check($sformatf("bad_done@%0h", a), 32'(done[0]), 32'd0);
    endtask

    initial begin
        rst = 2'b00; rd = 2'b00; wr = 2'b00;
        addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check($sformatf("u%0d_rst_stall", s), 32'(stall[s]), 32'd0);
            check($sformatf("u%0d_rst_rdata", s), rdata[s], 32'd0);
            check($sformatf("u%0d_rst_done", s), 32'(done[s]), 32'd0);
            check($sformatf("u%0d_rst_err", s), 32'(err[s]), 32'd0);
        end
        rst = 2'b11;

        // LATENCY=2: write then read, plus the last legal word.
        access(0, 1, 0, 32'h10,  32'hDEADBEEF, 0, 32'h0,        2);
        access(0, 0, 1, 32'h10,  32'h0,        0, 32'hDEADBEEF, 2);
        access(0, 1, 0, 32'h1FC, 32'hCAFEF00D, 0, 32'hDEADBEEF, 2);
        access(0, 0, 1, 32'h1FC, 32'h0,        0, 32'hCAFEF00D, 2);
        idle(0);

        // Misaligned and out-of-range requests.
        bad_read(32'h6,   32'hCAFEF00D);
        bad_read(32'h200, 32'hCAFEF00D);

        // Inputs scrambled while waiting must not disturb the latched write.
        access(0, 1, 0, 32'h8, 32'h11111111, 1, 32'hCAFEF00D, 2);
        access(0, 0, 1, 32'h8, 32'h0,        0, 32'h11111111, 2);
        idle(0);

        // Reset on the edge that would perform a pending write.
        @(negedge clk);
        wr[0] = 1'b1; rd[0] = 1'b0; addr[0] = 32'h8; wdata[0] = 32'hA5A5A5A5;
        #1;
        check("rstw_stall_T", 32'(stall[0]), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst[0] = 1'b0; wr[0] = 1'b0;
        #1;
        check("rstw_stall_forced", 32'(stall[0]), 32'd0);
        @(negedge clk);
        rst[0] = 1'b1;
        #1;
        check("rstw_done", 32'(done[0]), 32'd0);
        check("rstw_stall", 32'(stall[0]), 32'd0);
        check("rstw_rdata", rdata[0], 32'd0);
        idle(0);
        check("rstw_done_later", 32'(done[0]), 32'd0);
        access(0, 0, 1, 32'h8, 32'h0, 0, 32'h11111111, 2);

        // Both requests high: the write wins and rdata holds.
        access(0, 1, 1, 32'h4, 32'h55, 0, 32'h11111111, 2);
        access(0, 0, 1, 32'h4, 32'h0,  0, 32'h55,       2);

        // Back-to-back reads with the request held through RESP.
        access(0, 1, 0, 32'h0, 32'h00000A0A, 0, 32'h55, 2);
        idle(0);
        access(0, 0, 1, 32'h0, 32'h0, 0, 32'h00000A0A, 2);
        access(0, 0, 1, 32'h4, 32'h0, 0, 32'h55,       2);
        idle(0);

        // LATENCY=0 instance.
        access(1, 1, 0, 32'h0,  32'h12345678, 0, 32'h0,        0);
        access(1, 0, 1, 32'h0,  32'h0,        0, 32'h12345678, 0);
        access(1, 1, 0, 32'h40, 32'h0F0F0F0F, 0, 32'h12345678, 0);
        access(1, 0, 1, 32'h40, 32'h0,        0, 32'h0F0F0F0F, 0);
        idle(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
